// File: rtl/joystick_pkg.sv
// Shared definitions for the serial joystick reader: FSM state encoding
// and width helpers used to size the tick, bit and gap counters.
package joystick_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } joyState_e;

  // Ceiling log2; clog2(1) is 0.
  function automatic int clog2(input int value);
    int result = 0;
    int remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Bits needed to hold the values 0..maxValue, never less than one.
  function automatic int widthFor(input int maxValue);
    return (maxValue < 1) ? 1 : clog2(maxValue + 1);
  endfunction

endpackage

// File: rtl/joystick_serial_tick_div.sv
// Clock-enable generator: asserts tick for one clock every CLKDIV clocks.
// The count restarts from zero on reset, so the first tick after release
// arrives CLKDIV clocks later.
module tick_div
  import joystick_pkg::*;
#(
  parameter int CLKDIV = 50
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CntW = widthFor(CLKDIV - 1);
  localparam logic [CntW-1:0] LastCount = CntW'(CLKDIV - 1);

  logic [CntW-1:0] countReg;

  assign tick = (countReg == LastCount);

  // Free-running 0..CLKDIV-1 counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      countReg <= '0;
    end else if (tick) begin
      countReg <= '0;
    end else begin
      countReg <= countReg + 1'b1;
    end
  end

endmodule

// File: rtl/joystick_serial.sv
// Serial joystick deserializer for 74HC165-style adapter chains.
// Each frame pulses joyLd low for one tick, then clocks NPORTS*BITS bits in
// with joyCk, sampling the active-low data as joyCk falls. The first bit
// sampled ends up in joy[0]. A completed frame is published on joy with a
// one-clock valid strobe, followed by GAP idle ticks.
// Optional build macro JOY_DEBOUNCE_EN: a frame is only published when it
// matches the raw frame read just before it.
module joystick_serial
  import joystick_pkg::*;
#(
  parameter int CLKDIV = 50,
  parameter int NPORTS = 2,
  parameter int BITS   = 8,
  parameter int GAP    = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   joyCk,
  output logic                   joyLd,
  input  logic                   joyD,
  output logic [NPORTS*BITS-1:0] joy,
  output logic                   valid
);

  localparam int N    = NPORTS * BITS;
  localparam int BitW = widthFor(N);
  localparam int GapW = widthFor(GAP);

  localparam logic [BitW-1:0] LastBit  = BitW'(N - 1);
  localparam logic [GapW-1:0] GapReload = GapW'(GAP);

  logic tick;

  joyState_e       stateReg, stateNext;
  logic            joyCkReg, joyCkNext;
  logic            joyLdReg, joyLdNext;
  logic [GapW-1:0] gapReg, gapNext;
  logic [BitW-1:0] bitCntReg, bitCntNext;
  logic [N-1:0]    shiftReg, shiftNext;
  logic [N-1:0]    shiftIn;
  logic [N-1:0]    joyReg;
  logic            validReg;
  logic            frameDone;

  tick_div #(
    .CLKDIV(CLKDIV)
  ) tickGen (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // New bit enters at the top, so after N samples the first one sits at bit 0.
  generate
    if (N == 1) begin : gSingleBit
      assign shiftIn = ~joyD;
    end else begin : gChain
      assign shiftIn = {~joyD, shiftReg[N-1:1]};
    end
  endgenerate

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  // Next-state and serial-line control; everything advances only on tick.
  always_comb begin
    stateNext  = stateReg;
    joyCkNext  = joyCkReg;
    joyLdNext  = joyLdReg;
    gapNext    = gapReg;
    bitCntNext = bitCntReg;
    shiftNext  = shiftReg;
    frameDone  = 1'b0;
    if (tick) begin
      unique case (stateReg)
        IDLE: begin
          joyCkNext = 1'b0;
          joyLdNext = 1'b1;
          if (gapReg != '0) begin
            gapNext = gapReg - 1'b1;
          end else if (enable) begin
            stateNext  = LOAD;
            joyLdNext  = 1'b0;
            bitCntNext = '0;
          end
        end
        LOAD: begin
          joyLdNext  = 1'b1;
          joyCkNext  = 1'b0;
          bitCntNext = '0;
          stateNext  = SHIFT;
        end
        SHIFT: begin
          joyCkNext = ~joyCkReg;
          // joyCk is about to fall: the adapter's current bit is stable.
          if (joyCkReg) begin
            shiftNext  = shiftIn;
            bitCntNext = bitCntReg + 1'b1;
            if (bitCntReg == LastBit) begin
              frameDone = 1'b1;
              joyCkNext = 1'b0;
              gapNext   = GapReload;
              stateNext = IDLE;
            end
          end
        end
        default: begin
          stateNext = IDLE;
        end
      endcase
    end
  end

  // Serial-line, counter and shift-register storage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      joyCkReg  <= 1'b0;
      joyLdReg  <= 1'b1;
      gapReg    <= '0;
      bitCntReg <= '0;
      shiftReg  <= '0;
    end else begin
      joyCkReg  <= joyCkNext;
      joyLdReg  <= joyLdNext;
      gapReg    <= gapNext;
      bitCntReg <= bitCntNext;
      shiftReg  <= shiftNext;
    end
  end

`ifdef JOY_DEBOUNCE_EN
  logic [N-1:0] prevRawReg;

  // Publish only when two consecutive raw frames agree; valid lasts one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      joyReg     <= '0;
      validReg   <= 1'b0;
      prevRawReg <= '0;
    end else begin
      validReg <= 1'b0;
      if (frameDone) begin
        prevRawReg <= shiftNext;
        if (shiftNext == prevRawReg) begin
          joyReg   <= shiftNext;
          validReg <= 1'b1;
        end
      end
    end
  end
`else
  // Publish every completed frame; valid lasts one clock.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      joyReg   <= '0;
      validReg <= 1'b0;
    end else begin
      validReg <= 1'b0;
      if (frameDone) begin
        joyReg   <= shiftNext;
        validReg <= 1'b1;
      end
    end
  end
`endif

  assign joyCk = joyCkReg;
  assign joyLd = joyLdReg;
  assign joy   = joyReg;
  assign valid = validReg;

endmodule

// File: tb/tb_joystick_serial.sv
// Bench for joystick_serial: two instances (16-bit chain at CLKDIV=4/GAP=2,
// 48-bit chain at CLKDIV=2) each driven by a behavioural active-low 165 chain.
module tb_joystick_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        joyCk, joyLd, joyD, valid;
  logic [15:0] joy;

  logic        wideEnable = 1'b1;
  logic        wideCk, wideLd, wideD, wideValid;
  logic [47:0] wideJoy;

  always #5 clock = ~clock;

  joystick_serial #(.CLKDIV(4), .NPORTS(2), .BITS(8), .GAP(2)) dut (
    .clock (clock),
    .reset (reset),
    .enable(enable),
    .joyCk (joyCk),
    .joyLd (joyLd),
    .joyD  (joyD),
    .joy   (joy),
    .valid (valid)
  );

  joystick_serial #(.CLKDIV(2), .NPORTS(4), .BITS(12), .GAP(2)) dutWide (
    .clock (clock),
    .reset (reset),
    .enable(wideEnable),
    .joyCk (wideCk),
    .joyLd (wideLd),
    .joyD  (wideD),
    .joy   (wideJoy),
    .valid (wideValid)
  );

  // 165 chain models: parallel load while load is low, shift on falling clock,
  // output is the active-low version of the pressed bit at the chain end.
  logic [15:0] devPattern = 16'h0000;
  logic [15:0] devReg = 16'h0000;
  logic        devPrevCk = 1'b0;
  always @(negedge clock) begin
    if (!joyLd) devReg <= devPattern;
    else if (devPrevCk && !joyCk) devReg <= devReg >> 1;
    devPrevCk <= joyCk;
  end
  assign joyD = ~devReg[0];

  logic [47:0] wideDevPattern = 48'h8000_0000_0000;
  logic [47:0] wideDevReg = 48'h0;
  logic        wideDevPrevCk = 1'b0;
  always @(negedge clock) begin
    if (!wideLd) wideDevReg <= wideDevPattern;
    else if (wideDevPrevCk && !wideCk) wideDevReg <= wideDevReg >> 1;
    wideDevPrevCk <= wideCk;
  end
  assign wideD = ~wideDevReg[0];

  // Event monitor, sampled just after each rising edge.
  int   cycle = 0;
  int   validCount = 0;
  int   ldLowCount = 0;
  int   ckFallCount = 0;
  int   lastValidCycle = 0;
  logic monPrevCk = 1'b0;
  always @(posedge clock) begin
    #2;
    cycle++;
    if (valid) begin
      validCount++;
      lastValidCycle = cycle;
      $display("frame: joy=%h cycle=%0d", joy, cycle);
    end
    if (wideValid) $display("wide frame: joy=%h cycle=%0d", wideJoy, cycle);
    if (!joyLd) ldLowCount++;
    if (monPrevCk && !joyCk) ckFallCount++;
    monPrevCk = joyCk;
  end

  int compared = 0;
  int mismatched = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Wait (at falling edges) until joyLd reaches level; clocks = edges waited.
  task automatic waitLd(input logic level, input int maxClocks, input string tag, output int clocks);
    clocks = 0;
    while (joyLd !== level && clocks < maxClocks) begin
      @(negedge clock);
      clocks++;
    end
    if (joyLd !== level) checkVal({tag, "_timeout"}, joyLd, level);
  endtask

  // Always advances at least one clock, then waits for the next valid pulse.
  task automatic waitValid(input int maxClocks, input string tag);
    int clocks;
    @(negedge clock);
    clocks = 1;
    while (!valid && clocks < maxClocks) begin
      @(negedge clock);
      clocks++;
    end
    if (!valid) checkVal({tag, "_timeout"}, valid, 1'b1);
  endtask

  task automatic waitWideValid(input int maxClocks, input string tag);
    int clocks;
    @(negedge clock);
    clocks = 1;
    while (!wideValid && clocks < maxClocks) begin
      @(negedge clock);
      clocks++;
    end
    if (!wideValid) checkVal({tag, "_timeout"}, wideValid, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          snapCk, snapLd, snapValid, c1;
    logic [15:0] pats [3];
    int          expValid [3];

    pats[0] = 16'h0001;
    pats[1] = 16'h0003;
    pats[2] = 16'h0003;
`ifdef JOY_DEBOUNCE_EN
    expValid[0] = 0; expValid[1] = 0; expValid[2] = 1;
`else
    expValid[0] = 1; expValid[1] = 1; expValid[2] = 1;
`endif

    // Reset values.
    devPattern = 16'hA55A;
    repeat (3) @(negedge clock);
    checkVal("reset_joyCk", joyCk, 1'b0);
    checkVal("reset_joyLd", joyLd, 1'b1);
    checkVal("reset_joy", joy, 16'h0);
    checkVal("reset_valid", valid, 1'b0);

    // First load one tick after release, held low exactly one tick.
    reset = 1'b0;
    waitLd(1'b0, 40, "first_load", n);
    checkVal("first_load_clocks", n, 4);
    waitLd(1'b1, 40, "load_len", n);
    checkVal("load_low_clocks", n, 4);

    // Capture of A55A with 16 falling joyCk edges and one-clock valid.
    snapCk = ckFallCount;
    waitValid(300, "frame1");
    checkVal("frame1_joy", joy, 16'hA55A);
    checkVal("frame1_ck_falls", ckFallCount - snapCk, 16);
    c1 = lastValidCycle;
    @(negedge clock);
    checkVal("valid_width", valid, 1'b0);

    // Continuous frames, period (2+32+2)*4 clocks.
    devPattern = 16'h0F3C;
    waitValid(300, "frame2");
    checkVal("frame2_joy", joy, 16'h0F3C);
    checkVal("period_1", lastValidCycle - c1, 144);
    devPattern = 16'h8001;
    c1 = lastValidCycle;
    waitValid(300, "frame3");
    checkVal("frame3_joy", joy, 16'h8001);
    checkVal("period_2", lastValidCycle - c1, 144);

    // Enable dropped at bit 5: frame still completes, then no more loads.
    devPattern = 16'h1234;
    waitLd(1'b0, 200, "en_load", n);
    snapCk = ckFallCount;
    n = 0;
    while (ckFallCount - snapCk < 5 && n < 200) begin
      @(negedge clock);
      n++;
    end
    enable = 1'b0;
    waitValid(300, "en_frame");
    checkVal("en_frame_joy", joy, 16'h1234);
    snapLd = ldLowCount;
    snapValid = validCount;
    repeat (80) @(negedge clock);
    checkVal("disabled_no_load", ldLowCount - snapLd, 0);
    checkVal("disabled_no_valid", validCount - snapValid, 0);
    devPattern = 16'h5AA5;
    enable = 1'b1;
    waitLd(1'b0, 40, "reenable", n);
    checkVal("reenable_within_gap", n <= 12, 1'b1);

    // Async reset in the middle of SHIFT.
    waitLd(1'b1, 40, "mid_load", n);
    repeat (20) @(negedge clock);
    #1 reset = 1'b1;
    #1;
    checkVal("midreset_joyCk", joyCk, 1'b0);
    checkVal("midreset_joyLd", joyLd, 1'b1);
    checkVal("midreset_joy", joy, 16'h0);
    checkVal("midreset_valid", valid, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    snapValid = validCount;
    waitLd(1'b0, 40, "midreset_load", n);
    checkVal("midreset_first_load", n, 4);
    repeat (100) @(negedge clock);
    checkVal("partial_joy_zero", joy, 16'h0);
    checkVal("partial_no_valid", validCount - snapValid, 0);
    waitValid(300, "after_reset");
    checkVal("after_reset_joy", joy, 16'h5AA5);

    // Frames 0001, 0003, 0003.
    for (int i = 0; i < 3; i++) begin
      devPattern = pats[i];
      waitLd(1'b0, 200, "db_load", n);
      waitLd(1'b1, 40, "db_load_end", n);
      snapValid = validCount;
      repeat (136) @(negedge clock);
      checkVal($sformatf("db_valid_frame%0d", i), validCount - snapValid, expValid[i]);
    end
    checkVal("db_joy", joy, 16'h0003);

    // Wide chain: only bit 47 pressed.
    waitWideValid(600, "wide");
    checkVal("wide_joy", wideJoy, 48'h8000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
